// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register map, status bit indices and region sizes for mmio_data_responder
package mmio_pkg;

   localparam int unsigned IO_REGION_BYTES = 32;

   localparam logic [4:0] OFF_PORT_IN   = 5'h00;
   localparam logic [4:0] OFF_PORT_OUT  = 5'h04;
   localparam logic [4:0] OFF_STATUS    = 5'h08;
   localparam logic [4:0] OFF_IRQ_EN    = 5'h0C;
   localparam logic [4:0] OFF_TIMER     = 5'h10;
   localparam logic [4:0] OFF_TIMER_CMP = 5'h14;

   localparam int unsigned STATUS_IN_CHANGE   = 0;
   localparam int unsigned STATUS_TIMER_MATCH = 1;

endpackage

// File: rtl/input_synchronizer.sv
// rtl/input_synchronizer.sv - two-flop synchronizer for an asynchronous input bus
module input_synchronizer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/mmio_data_responder.sv
// rtl/mmio_data_responder.sv - data-bus target: word RAM plus MMIO registers; MMIO_TIMER_EN adds timer/compare
module mmio_data_responder
   import mmio_pkg::*;
#(
   parameter int unsigned MEMORY_DEPTH = 512,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
   parameter logic [31:0] IO_BASE      = 32'hFFFF_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [31:0]           address,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic [7:0]            port_in,
   output logic [DATA_WIDTH-1:0] port_out,
   output logic                  bus_error,
   output logic                  irq
);

   localparam int unsigned RAM_AW  = $clog2(MEMORY_DEPTH);
   localparam logic [31:0] RAM_END = RAM_BASE + 32'(4 * MEMORY_DEPTH);
   localparam logic [31:0] IO_END  = IO_BASE + 32'(IO_REGION_BYTES);

   logic [DATA_WIDTH-1:0] ram_q [MEMORY_DEPTH];
   logic [31:0]           ram_off, io_off;
   logic [RAM_AW-1:0]     ram_idx;
   logic                  ram_hit, io_hit, illegal, ram_we, io_we;
   logic [7:0]            sync2, sync3_q;
   logic [DATA_WIDTH-1:0] port_out_q, port_out_d, io_rdata;
   logic [1:0]            status_q, status_d, status_set, irq_en_q, irq_en_d;
   logic                  bus_error_q, irq_q;
   logic                  unused_addr_bits;
`ifdef MMIO_TIMER_EN
   logic [31:0]           timer_q, cmp_q, cmp_d;
`endif

   input_synchronizer #(.WIDTH(8)) u_sync (
      .clk    (clk),
      .rst_n  (reset),
      .async_i(port_in),
      .sync_o (sync2)
   );

   assign ram_off = address - RAM_BASE;
   assign io_off  = address - IO_BASE;
   assign ram_idx = ram_off[RAM_AW+1:2];
   assign ram_hit = (address >= RAM_BASE) && (address < RAM_END);
   assign io_hit  = (address >= IO_BASE) && (address < IO_END);
   assign illegal = (mem_read | mem_write) &
                    ((|address[1:0]) | !(ram_hit | io_hit) | (mem_read & mem_write));
   // Reset gates the RAM port so a store caught by reset assertion is dropped.
   assign ram_we  = mem_write & ~illegal & ram_hit & reset;
   assign io_we   = mem_write & ~illegal & io_hit;
   assign unused_addr_bits = ^{ram_off[31:RAM_AW+2], ram_off[1:0], io_off[31:5]};

   always_comb begin
      io_rdata = '0;
      case (io_off[4:0])
         OFF_PORT_IN:   io_rdata = DATA_WIDTH'(sync2);
         OFF_PORT_OUT:  io_rdata = port_out_q;
         OFF_STATUS:    io_rdata = DATA_WIDTH'(status_q);
         OFF_IRQ_EN:    io_rdata = DATA_WIDTH'(irq_en_q);
`ifdef MMIO_TIMER_EN
         OFF_TIMER:     io_rdata = timer_q;
         OFF_TIMER_CMP: io_rdata = cmp_q;
`endif
         default:       io_rdata = '0;
      endcase
   end

   assign read_data = (mem_read && !illegal) ? (ram_hit ? ram_q[ram_idx] : io_rdata) : '0;

   always_comb begin
      status_set = '0;
      status_set[STATUS_IN_CHANGE] = (sync2 != sync3_q);
`ifdef MMIO_TIMER_EN
      status_set[STATUS_TIMER_MATCH] = (timer_q == cmp_q);
      cmp_d = cmp_q;
`endif
      status_d   = status_q;
      port_out_d = port_out_q;
      irq_en_d   = irq_en_q;
      if (io_we) begin
         case (io_off[4:0])
            OFF_PORT_OUT:  port_out_d = write_data;
            OFF_STATUS:    status_d   = status_q & ~write_data[1:0];
            OFF_IRQ_EN:    irq_en_d   = write_data[1:0];
`ifdef MMIO_TIMER_EN
            OFF_TIMER_CMP: cmp_d      = write_data;
`endif
            default:       ;
         endcase
      end
      // New events are ORed in after the W1C so a simultaneous set survives.
      status_d = status_d | status_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync3_q     <= '0;
         port_out_q  <= '0;
         status_q    <= '0;
         irq_en_q    <= '0;
         bus_error_q <= 1'b0;
         irq_q       <= 1'b0;
`ifdef MMIO_TIMER_EN
         timer_q     <= '0;
         cmp_q       <= '1;
`endif
      end else begin
         sync3_q     <= sync2;
         port_out_q  <= port_out_d;
         status_q    <= status_d;
         irq_en_q    <= irq_en_d;
         bus_error_q <= illegal;
         irq_q       <= |(status_q & irq_en_q);
`ifdef MMIO_TIMER_EN
         timer_q     <= timer_q + 32'd1;
         cmp_q       <= cmp_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= write_data;
      end
   end

   assign port_out  = port_out_q;
   assign bus_error = bus_error_q;
   assign irq       = irq_q;

endmodule
